// File: rtl/blur_frame_sequencer.sv
// Raster-scan read sequencer for the 3x3 blur pipeline: issues pixel reads, flags complete
// windows, and emits output write strobes/addresses after the kernel latency.
module blur_frame_sequencer #(
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned IMG_H  = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned KLAT   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stall,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic                     win_valid,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned DW = $clog2(KLAT + 2);

  localparam logic [RW-1:0] RowLast  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] ColLast  = CW'(IMG_W - 1);
  localparam logic [DW-1:0] DrainEnd = DW'(KLAT);

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

  state_e        state_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [DW-1:0] drain_q;

  assign rd_en = (state_q == StScan) && !stall;
  assign busy  = (state_q != StIdle);
  assign done  = (state_q == StDone);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      row_q     <= '0;
      col_q     <= '0;
      drain_q   <= '0;
      rd_addr   <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else begin
      win_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StScan;
            row_q   <= '0;
            col_q   <= '0;
            rd_addr <= '0;
          end
        end
        StScan: begin
          if (rd_en) begin
            // Window centred one row/col behind the pixel just read.
            if (row_q >= RW'(2) && col_q >= CW'(2)) begin
              win_valid <= 1'b1;
              win_row   <= row_q - RW'(1);
              win_col   <= col_q - CW'(1);
            end
            if (col_q == ColLast) begin
              col_q <= '0;
              if (row_q == RowLast) begin
                row_q   <= '0;
                rd_addr <= '0;
                drain_q <= '0;
                state_q <= StDrain;
              end else begin
                row_q   <= row_q + RW'(1);
                rd_addr <= rd_addr + ADDR_W'(1);
              end
            end else begin
              col_q   <= col_q + CW'(1);
              rd_addr <= rd_addr + ADDR_W'(1);
            end
          end
        end
        StDrain: begin
          if (drain_q == DrainEnd) begin
            state_q <= StDone;
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Kernel latency line; runs regardless of stall so in-flight results still land.
  if (KLAT == 0) begin : g_no_dly
    assign wr_en = win_valid;
  end else begin : g_dly
    logic [KLAT-1:0] dly_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dly_q <= '0;
      end else begin
        dly_q[0] <= win_valid;
        for (int i = 1; i < KLAT; i++) begin
          dly_q[i] <= dly_q[i-1];
        end
      end
    end
    assign wr_en = dly_q[KLAT-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr <= '0;
    end else if (state_q == StIdle && start) begin
      wr_addr <= '0;
    end else if (wr_en) begin
      wr_addr <= wr_addr + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_blur_frame_sequencer.sv
// Directed bench: a 4x4/KLAT=2 instance for scan, stall, start-while-busy and reset cases,
// plus a 3x3/KLAT=0 instance for the single-window boundary case.
module tb_blur_frame_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start4 = 1'b0, stall4 = 1'b0;
  logic       rd_en4, win_valid4, wr_en4, busy4, done4;
  logic [3:0] rd_addr4, wr_addr4;
  logic [1:0] win_row4, win_col4;

  logic       start3 = 1'b0, stall3 = 1'b0;
  logic       rd_en3, win_valid3, wr_en3, busy3, done3;
  logic [3:0] rd_addr3, wr_addr3;
  logic [1:0] win_row3, win_col3;

  blur_frame_sequencer #(.IMG_W(4), .IMG_H(4), .ADDR_W(4), .KLAT(2)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .stall(stall4),
    .rd_en(rd_en4), .rd_addr(rd_addr4), .win_valid(win_valid4),
    .win_row(win_row4), .win_col(win_col4), .wr_en(wr_en4), .wr_addr(wr_addr4),
    .busy(busy4), .done(done4)
  );

  blur_frame_sequencer #(.IMG_W(3), .IMG_H(3), .ADDR_W(4), .KLAT(0)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .stall(stall3),
    .rd_en(rd_en3), .rd_addr(rd_addr3), .win_valid(win_valid3),
    .win_row(win_row3), .win_col(win_col3), .wr_en(wr_en3), .wr_addr(wr_addr3),
    .busy(busy3), .done(done3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Per-frame statistics for dut4, sampled on the falling edge.
  int cyc = 0;
  int rd_cnt, rd_seq_err, win_cnt, wr_cnt, busy_cnt, done_cnt;
  int first_win_cyc, first_wr_cyc, last_wr_cyc, done_cyc;
  int win_log[8];
  int wr_log[8];

  task automatic clear_stats();
    rd_cnt = 0; rd_seq_err = 0; win_cnt = 0; wr_cnt = 0; busy_cnt = 0; done_cnt = 0;
    first_win_cyc = 0; first_wr_cyc = 0; last_wr_cyc = 0; done_cyc = 0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (busy4) busy_cnt++;
    if (done4) begin done_cnt++; done_cyc = cyc; end
    if (rd_en4) begin
      if (rd_addr4 !== rd_cnt[3:0]) rd_seq_err++;
      rd_cnt++;
    end
    if (win_valid4) begin
      if (win_cnt == 0) first_win_cyc = cyc;
      if (win_cnt < 8) win_log[win_cnt] = int'(win_row4) * 16 + int'(win_col4);
      win_cnt++;
    end
    if (wr_en4) begin
      if (wr_cnt == 0) first_wr_cyc = cyc;
      if (wr_cnt < 8) wr_log[wr_cnt] = int'(wr_addr4);
      wr_cnt++;
      last_wr_cyc = cyc;
    end
  end

  // Runs one 4x4 frame; stall_addr >= 0 stalls 3 cycles on that read, poke pulses start
  // mid-scan and during DONE.
  task automatic frame4(input int stall_addr, input bit poke);
    bit stalled   = 1'b0;
    bit seen_done = 1'b0;
    int n = 0;
    clear_stats();
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    while (!seen_done && n < 100) begin
      n++;
      start4 = 1'b0;
      if (stall_addr >= 0 && !stalled && busy4 && rd_addr4 == stall_addr[3:0]) begin
        stalled = 1'b1;
        stall4  = 1'b1;
        for (int k = 0; k < 3; k++) begin
          #1;
          check_eq("stall_rd_en", rd_en4, 0);
          check_eq("stall_rd_addr", rd_addr4, stall_addr);
          @(posedge clk); #1;
        end
        stall4 = 1'b0;
        #1;
        check_eq("unstall_rd_en", rd_en4, 1);
        check_eq("unstall_rd_addr", rd_addr4, stall_addr);
      end
      if (poke && busy4 && rd_addr4 == 4'd5) start4 = 1'b1;
      if (poke && done4) start4 = 1'b1;
      if (done4) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    start4 = 1'b0;
    check_eq("frame_done_seen", seen_done, 1);
  endtask

  task automatic check_frame4(input int exp_busy);
    int exp_win[4] = '{'h11, 'h12, 'h21, 'h22};
    check_eq("rd_count", rd_cnt, 16);
    check_eq("rd_addr_seq_err", rd_seq_err, 0);
    check_eq("win_count", win_cnt, 4);
    for (int i = 0; i < 4; i++) check_eq("win_rowcol", win_log[i], exp_win[i]);
    check_eq("wr_count", wr_cnt, 4);
    for (int i = 0; i < 4; i++) check_eq("wr_addr", wr_log[i], i);
    check_eq("wr_lag", first_wr_cyc - first_win_cyc, 2);
    check_eq("done_after_last_wr", done_cyc - last_wr_cyc, 1);
    check_eq("busy_cycles", busy_cnt, exp_busy);
    check_eq("done_pulses", done_cnt, 1);
  endtask

  initial begin
    int n;
    int win_c, wr_n, busy_n, done_c, last_rd_c;

    // Reset state
    #3;
    check_eq("rst_outputs", {rd_en4, rd_addr4, win_valid4, win_row4, win_col4, wr_en4,
                             wr_addr4, busy4, done4}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Idle with start low
    clear_stats();
    repeat (10) @(posedge clk);
    #1;
    check_eq("idle_busy", busy_cnt, 0);

    frame4(-1, 1'b0);
    check_frame4(20);

    frame4(9, 1'b0);
    check_frame4(23);

    frame4(-1, 1'b1);
    check_frame4(20);
    clear_stats();
    repeat (5) @(posedge clk);
    #1;
    check_eq("post_poke_idle_busy", busy_cnt, 0);

    // Fresh frame after a completed one
    frame4(-1, 1'b0);
    check_frame4(20);

    // Reset mid-frame at read 10
    clear_stats();
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    n = 0;
    while (rd_addr4 != 4'd10 && n < 30) begin
      n++;
      @(posedge clk); #1;
    end
    check_eq("reached_read10", rd_addr4, 10);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_outputs", {rd_en4, rd_addr4, win_valid4, win_row4, win_col4, wr_en4,
                                wr_addr4, busy4, done4}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_eq("midrst_no_done", done_cnt, 0);
    check_eq("midrst_wr_en", wr_en4, 0);
    check_eq("midrst_busy", busy4, 0);
    frame4(-1, 1'b0);
    check_frame4(20);

    // 3x3, KLAT=0 boundary frame
    win_c = 0; wr_n = 0; busy_n = 0; done_c = 0; last_rd_c = 0;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (rd_en3 && rd_addr3 == 4'd8) last_rd_c = c;
      if (win_valid3) begin
        win_c = c;
        check_eq("k0_win_row", win_row3, 1);
        check_eq("k0_win_col", win_col3, 1);
        check_eq("k0_wr_same_cycle", wr_en3, 1);
        check_eq("k0_wr_addr", wr_addr3, 0);
      end
      if (wr_en3) wr_n++;
      if (busy3) busy_n++;
      if (done3) begin
        done_c = c;
        break;
      end
      @(posedge clk); #1;
    end
    check_eq("k0_last_read_cycle", last_rd_c, 9);
    check_eq("k0_win_cycle", win_c, 10);
    check_eq("k0_wr_count", wr_n, 1);
    check_eq("k0_done_cycle", done_c, 11);
    check_eq("k0_busy_cycles", busy_n, 11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blur_frame_sequencer.md
# blur_frame_sequencer

Control sequencer for the Gaussian blur pipeline. It scans an input frame in raster order and issues pixel reads to the image memory. It flags each cycle on which the external line buffers hold a complete 3x3 window, and generates write strobes and addresses for blurred output pixels after the fixed kernel latency. It sits between the frame memory/file-read front end and the kernel datapath/file-write back end, and owns frame start/finish handshaking.

## Interface
- IMG_W, 32: input frame width in pixels (>=3)
- IMG_H, 32: input frame height in pixels (>=3)
- ADDR_W, 10: read/write address width; must hold IMG_W*IMG_H-1
- KLAT, 2: kernel datapath latency in cycles from win_valid to result (>=0)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  frame start request; sampled only in IDLE
- stall  in  1  back-pressure from memory side; suppresses new reads
- rd_en  out  1  pixel read strobe; memory returns data next cycle
- rd_addr  out  ADDR_W  read address, row*IMG_W+col
- win_valid  out  1  3x3 window complete this cycle
- win_row  out  $clog2(IMG_H)  centre row of current window
- win_col  out  $clog2(IMG_W)  centre column of current window
- wr_en  out  1  blurred pixel write strobe
- wr_addr  out  ADDR_W  output address, 0..(IMG_W-2)*(IMG_H-2)-1
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the frame completes

## Operation
- FSM states: IDLE, SCAN, DRAIN, DONE. Reset state is IDLE.
- IDLE -> SCAN when start=1. start is ignored in all other states.
- SCAN:
  - rd_en = !stall (combinational from state).
  - On each issued read, the row/col counters advance: col wraps IMG_W-1 -> 0 with row+1.
  - rd_addr is a registered incrementing counter, never a multiplier.
  - The read of (IMG_H-1, IMG_W-1) moves the FSM to DRAIN and clears the counters.
- Window detect: a read issued at (r,c) with r>=2 and c>=2 produces win_valid=1 one cycle later, with win_row=r-1 and win_col=c-1. No edge padding. The output frame is (IMG_W-2)x(IMG_H-2).
- Write path: win_valid passes through a KLAT-deep shift register (unconditional, unaffected by stall) and becomes wr_en. wr_addr starts at 0 per frame and increments after each wr_en.
- DRAIN: rd_en=0. Stays in DRAIN for exactly KLAT+1 cycles, then moves to DONE.
- DONE: done=1 for one cycle, then IDLE. busy=1 in SCAN, DRAIN and DONE.
- stall held in SCAN: no reads, counters frozen, win_valid=0 on the following cycle. The in-flight write pipeline continues to drain.
- Reset values: all outputs 0 (rd_en, rd_addr, win_valid, win_row, win_col, wr_en, wr_addr, busy, done). Counters and the delay line are cleared.
- rst mid-frame: immediate return to IDLE with all outputs 0. No done pulse. Pending writes are discarded.
- start asserted in the same cycle done is high: ignored, because the FSM is not yet in IDLE. A new frame requires start in IDLE.

## Timing
- Edge E samples start=1 in IDLE. After E: busy=1, rd_en=1, rd_addr=0.
- Without stall, one read per cycle: IMG_W*IMG_H SCAN cycles.
- win_valid follows its triggering read by 1 cycle. wr_en follows win_valid by KLAT cycles.
- Final write occurs in the last DRAIN cycle. done is high in the cycle after the last DRAIN cycle.
- Unstalled frame: busy high for IMG_W*IMG_H + KLAT + 2 cycles.
- Every stalled cycle adds exactly one cycle to the frame time.

## Test plan
- Reset/idle: assert rst asynchronously mid-cycle -> all outputs 0 immediately. Holding start=0 keeps busy=0 indefinitely.
- Small frame, IMG_W=IMG_H=4, KLAT=2, no stall:
  - 16 reads, rd_addr 0..15.
  - win_valid pulses with (row,col) = (1,1),(1,2),(2,1),(2,2).
  - 4 wr_en with wr_addr 0..3.
  - busy lasts 20 cycles, then a single done pulse.
- Stall: 4x4 frame with stall=1 for 3 cycles during the read of pixel 9 -> rd_addr holds at 9 with rd_en=0. Total busy is 23 cycles. Write count and addresses are unchanged.
- Start while busy: pulse start during SCAN and during DONE -> no effect. Exactly one frame is processed. A second start in IDLE runs a fresh frame with wr_addr restarting at 0.
- Reset mid-frame: assert rst at read 10 of a 4x4 frame -> IDLE, no done, wr_en=0. The next start completes a full, correct frame.
- Wrap/boundary, IMG_W=IMG_H=3, KLAT=0: a single window (1,1) on read 8. wr_en occurs in the same cycle as win_valid with wr_addr=0. done follows after 1 DRAIN cycle.
